spi_cmos_lane_rx: RTL and testbench
===================================

Name: spi_cmos_lane_rx

Overview:
Parametrised successor to the single-lane CMOS SPI capture path. Samples an externally clocked SPI stream (sck_in, cs_n_in, LANES miso lines) in the sys_clk domain and deserialises WORD_W bits per lane, MSB first. Completed words are buffered in a first-word-fall-through FIFO and presented on a valid/ready interface, tagged with end-of-row. Sits between the CMOS/ESP32 SPI pins and the frame packer / DAQ write path.

Parameters:
WORD_W, 32, bits per word per lane (≥2)
LANES, 1, number of parallel miso lanes (1..8)
DEPTH, 16, FIFO depth in words, power of 2 (≥4)
ROW_LEN, 304, words per sensor row, used for m_eol
AW, log2(DEPTH), derived localparam, not overridable

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  reset
sck_in  in  1  external SPI clock, asynchronous to sys_clk
cs_n_in  in  1  external chip select, active low
miso  in  LANES  serial data; lane i fills m_data[i*WORD_W +: WORD_W]
m_data  out  LANES*WORD_W  FIFO head word
m_eol  out  1  head word is the last word of a row
m_valid  out  1  FIFO not empty
m_ready  in  1  consumer accepts head word when m_valid=1
fifo_level  out  AW+1  words currently stored, 0..DEPTH
overflow  out  1  sticky: completed word dropped because FIFO was full
frame_err  out  1  one-cycle pulse: cs_n_in deasserted mid-word
clr_flags  in  1  clears overflow

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. sys_clk is the clock, sys_rst the reset. At reset, m_valid=0, m_eol=0, m_data=0, fifo_level=0, overflow=0, frame_err=0. Shift registers, bit counter, row counter and FIFO pointers clear. FSM goes to IDLE.
- Input sync: sck_in, cs_n_in and miso each pass through a 2-FF synchroniser, plus a third sck stage for edge detection. Rise is sck_s2 & ~sck_s3. miso is sampled from its s2 stage on the same cycle. sck_in high and low phases are each ≥2 sys_clk periods.
- FSM IDLE: wait for synced cs_n low, then go to SHIFT with bit_cnt=0.
- FSM SHIFT: each sck rise shifts every lane's s2 bit into the LSB of that lane's register and increments bit_cnt.
  - On the rise with bit_cnt=WORD_W-1, the word is complete: bit_cnt returns to 0, a push request is registered, and the FSM stays in SHIFT.
  - Synced cs_n high with bit_cnt=0: go to IDLE silently.
  - Synced cs_n high with bit_cnt≠0: frame_err=1 for exactly one cycle, partial word discarded, go to IDLE.
  - A sck rise and a cs_n rise in the same cycle: the shift is taken first, then the cs_n rule is evaluated on the new bit_cnt.
- Latency: the final sck_in high is captured into sync stage 1 at edge N. The shift completes at N+2, the FIFO write at N+3, and m_valid is high from N+3 when the FIFO was empty.
- Row counter: 0..ROW_LEN-1. Advances on every completed word, including dropped words, so row alignment is preserved. Wraps to 0. It is not reset by cs_n; a row may span transactions. The pushed entry stores eol = (row_cnt == ROW_LEN-1).
- FIFO: DEPTH entries of LANES*WORD_W+1 bits; m_data/m_eol always show the head entry.
  - Pop when m_valid & m_ready.
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - A push when full with no pop drops the word and sets overflow.
  - Pointers wrap modulo DEPTH. fifo_level is unchanged on a simultaneous push and pop.
  - Pop with FIFO empty is ignored.
- overflow: clr_flags clears it. If clr_flags and a new drop occur in the same cycle, set wins.
- sys_rst mid-word or mid-transaction: everything clears. The receiver resynchronises only on the next cs_n falling edge; an already-low cs_n is ignored until it goes high.

Optional Feature:
Macro SPI_CMOS_RX_STATS_EN.
- Defined: adds output drop_cnt [15:0], counting dropped words; saturates at 0xFFFF; cleared by sys_rst and by clr_flags (an increment in the same cycle as clr_flags yields 1). Adds output err_cnt [15:0], counting frame_err pulses, with the same saturation and clear rules.
- Not defined: neither port exists and no counter logic is synthesised.

Test Plan:
1. LANES=1, WORD_W=32: two CS transactions, each 32 sck cycles of bits 0x02E5CB94 with cs_n high between -> two FIFO entries 0x02E5CB94 in order, m_eol=0, frame_err never pulses.
2. cs_n_in raised after 20 bits, then a full word 0x12345678 -> frame_err is one cycle high, only 0x12345678 is stored, fifo_level=1.
3. m_ready=0, DEPTH=16, send 17 words 0..16 -> fifo_level=16 and overflow=1; draining yields 0..15; clr_flags clears overflow; with STATS_EN, drop_cnt=1.
4. ROW_LEN=4, send 9 words with m_ready=1 -> m_eol high on words 4 and 8 only; row counter continues across separate CS transactions.
5. LANES=2, WORD_W=8: lane0 0xA5, lane1 0x3C -> m_data=0x3CA5; full and push with pop in the same cycle -> word accepted, fifo_level unchanged, overflow stays 0.
6. sys_rst pulsed after 10 bits with cs_n held low -> all outputs 0; nothing captured until cs_n toggles high then low; the next word is received correctly.

Source files
------------

// File: rtl/spi_cmos_lane_rx.sv
// Multi-lane SPI capture: sync, deserialise MSB first, FWFT FIFO with end-of-row tag.
// Optional drop/error counters when SPI_CMOS_RX_STATS_EN is defined.
module spi_cmos_lane_rx #(
    parameter int WORD_W  = 32,
    parameter int LANES   = 1,
    parameter int DEPTH   = 16,
    parameter int ROW_LEN = 304
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      sck_in,
    input  logic                      cs_n_in,
    input  logic [LANES-1:0]          miso,
    output logic [LANES*WORD_W-1:0]   m_data,
    output logic                      m_eol,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      overflow,
    output logic                      frame_err,
    input  logic                      clr_flags
`ifdef SPI_CMOS_RX_STATS_EN
    ,
    output logic [15:0]               drop_cnt,
    output logic [15:0]               err_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = LANES * WORD_W;
    localparam int BW = $clog2(WORD_W);
    localparam int RW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic             sck_s1, sck_s2, sck_s3;
    logic             cs_s1, cs_s2;
    logic [LANES-1:0] miso_s1, miso_s2;
    logic             rise;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_s3  <= 1'b0;
            cs_s1   <= 1'b0;
            cs_s2   <= 1'b0;
            miso_s1 <= '0;
            miso_s2 <= '0;
        end else begin
            sck_s1  <= sck_in;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            cs_s1   <= cs_n_in;
            cs_s2   <= cs_s1;
            miso_s1 <= miso;
            miso_s2 <= miso_s1;
        end
    end

    assign rise = sck_s2 & ~sck_s3;

    state_t          state;
    logic            armed;
    logic [BW-1:0]   bit_cnt;
    logic [BW-1:0]   bit_nxt;
    logic [DW-1:0]   shreg;
    logic [DW-1:0]   sh_nxt;
    logic            word_done;
    logic            row_last;
    logic [RW-1:0]   row_cnt;
    logic            push_req;
    logic [DW-1:0]   push_word;
    logic            push_eol;

    always_comb begin
        sh_nxt = shreg;
        for (int i = 0; i < LANES; i++) begin
            sh_nxt[i*WORD_W +: WORD_W] =
                {shreg[i*WORD_W +: WORD_W-1], miso_s2[i]};
        end
    end

    assign word_done = rise && (bit_cnt == BW'(WORD_W - 1));
    assign bit_nxt   = word_done ? '0 : bit_cnt + BW'(1);
    assign row_last  = (row_cnt == RW'(ROW_LEN - 1));

    // armed blocks a cs_n that was already low when reset released
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            armed     <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            row_cnt   <= '0;
            push_req  <= 1'b0;
            push_word <= '0;
            push_eol  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push_req  <= 1'b0;
            frame_err <= 1'b0;
            if (cs_s2)
                armed <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (!cs_s2 && armed) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        shreg   <= sh_nxt;
                        bit_cnt <= bit_nxt;
                        if (word_done) begin
                            push_req  <= 1'b1;
                            push_word <= sh_nxt;
                            push_eol  <= row_last;
                            row_cnt   <= row_last ? '0 : row_cnt + RW'(1);
                        end
                    end
                    // shift first, then judge cs_n on the updated count
                    if (cs_s2) begin
                        state <= IDLE;
                        if ((rise ? bit_nxt : bit_cnt) != '0)
                            frame_err <= 1'b1;
                    end
                end
            endcase
        end
    end

    logic [DW:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          full, pop, acc, drop;
    logic [DW:0]   head;

    assign full    = (level == (AW+1)'(DEPTH));
    assign m_valid = (level != '0);
    assign pop     = m_valid & m_ready;
    assign acc     = push_req & (~full | pop);
    assign drop    = push_req & full & ~pop;

    always_ff @(posedge sys_clk) begin
        if (acc)
            mem[wr_ptr] <= {push_eol, push_word};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (acc && !pop)
                level <= level + (AW+1)'(1);
            else if (!acc && pop)
                level <= level - (AW+1)'(1);
            if (drop)
                overflow <= 1'b1;
            else if (clr_flags)
                overflow <= 1'b0;
        end
    end

    assign head       = mem[rd_ptr];
    assign m_data     = m_valid ? head[DW-1:0] : '0;
    assign m_eol      = m_valid & head[DW];
    assign fifo_level = level;

`ifdef SPI_CMOS_RX_STATS_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            drop_cnt <= '0;
        end else if (clr_flags) begin
            drop_cnt <= drop ? 16'd1 : 16'd0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            err_cnt <= '0;
        end else if (clr_flags) begin
            err_cnt <= frame_err ? 16'd1 : 16'd0;
        end else if (frame_err && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_cmos_lane_rx.sv
// Scoreboard bench for spi_cmos_lane_rx with two 8-bit lanes, depth 4, row of 4.
// Expected words are queued at stimulus time and checked as the DUT pops them.
module tb_spi_cmos_lane_rx;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        sck_in = 1'b0;
    logic        cs_n_in = 1'b1;
    logic [1:0]  miso = 2'b00;
    logic        m_ready = 1'b1;
    logic        clr_flags = 1'b0;
    logic [15:0] m_data;
    logic        m_eol;
    logic        m_valid;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        frame_err;
`ifdef SPI_CMOS_RX_STATS_EN
    logic [15:0] drop_cnt;
    logic [15:0] err_cnt;
`endif

    spi_cmos_lane_rx #(
        .WORD_W(8),
        .LANES(2),
        .DEPTH(4),
        .ROW_LEN(4)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .sck_in(sck_in),
        .cs_n_in(cs_n_in),
        .miso(miso),
        .m_data(m_data),
        .m_eol(m_eol),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .frame_err(frame_err),
`ifdef SPI_CMOS_RX_STATS_EN
        .drop_cnt(drop_cnt),
        .err_cnt(err_cnt),
`endif
        .clr_flags(clr_flags)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          err_cycles = 0;
    int          row = 0;
    logic [16:0] exp_q[$];
    logic [16:0] mon_e;

    task automatic check(string nm, int act, int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // pop_at_push raises m_ready exactly on the FIFO write edge of this bit
    task automatic send_bit(logic [1:0] b, bit pop_at_push);
        sck_in = 1'b0;
        miso   = b;
        tick(3);
        sck_in = 1'b1;
        if (pop_at_push) begin
            tick(2);
            @(posedge sys_clk);
            #1;
            m_ready = 1'b1;
            @(posedge sys_clk);
            #1;
            m_ready = 1'b0;
        end else begin
            tick(3);
        end
    endtask

    task automatic send_word(logic [15:0] w, bit stored, bit pop_at_push);
        if (stored)
            exp_q.push_back({row == 3, w});
        row = (row + 1) % 4;
        for (int b = 7; b >= 0; b--)
            send_bit({w[8+b], w[b]}, pop_at_push && b == 0);
    endtask

    task automatic cs_low();
        cs_n_in = 1'b0;
        tick(2);
    endtask

    task automatic cs_high();
        cs_n_in = 1'b1;
        tick(6);
    endtask

    always @(negedge sys_clk) begin
        if (frame_err)
            err_cycles++;
        if (!sys_rst && m_valid && m_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_word: got %h, expected none",
                         {m_eol, m_data});
            end else begin
                mon_e = exp_q.pop_front();
                if ({m_eol, m_data} == mon_e)
                    n_pass++;
                else
                    $display("FAIL word: got %h, expected %h",
                             {m_eol, m_data}, mon_e);
            end
        end
    end

    initial begin
        tick(3);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_eol", m_eol, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ferr", frame_err, 0);
        sys_rst = 1'b0;
        tick(4);

        cs_low();
        send_word(16'h3CA5, 1, 0);
        cs_high();
        cs_low();
        send_word(16'h1234, 1, 0);
        cs_high();
        check("no_ferr", err_cycles, 0);

        m_ready = 1'b0;
        cs_low();
        for (int i = 0; i < 5; i++)
            send_bit(2'b11, 0);
        cs_high();
        check("ferr_width", err_cycles, 1);
`ifdef SPI_CMOS_RX_STATS_EN
        check("err_cnt", err_cnt, 1);
`endif
        cs_low();
        send_word(16'h5678, 1, 0);
        cs_high();
        check("level_after_err", fifo_level, 1);
        m_ready = 1'b1;
        tick(3);

        cs_low();
        send_word(16'h9ABC, 1, 0);
        cs_high();
        cs_low();
        send_word(16'hDEF0, 1, 0);
        cs_high();
        tick(4);

        m_ready = 1'b0;
        cs_low();
        send_word(16'h0101, 1, 0);
        send_word(16'h0202, 1, 0);
        send_word(16'h0303, 1, 0);
        send_word(16'h0404, 1, 0);
        send_word(16'h0505, 0, 0);
        cs_high();
        check("full_level", fifo_level, 4);
        check("ovf_set", overflow, 1);
        check("full_valid", m_valid, 1);
`ifdef SPI_CMOS_RX_STATS_EN
        check("drop_cnt", drop_cnt, 1);
`endif
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check("ovf_clr", overflow, 0);
`ifdef SPI_CMOS_RX_STATS_EN
        check("drop_clr", drop_cnt, 0);
        check("err_clr", err_cnt, 0);
`endif

        cs_low();
        send_word(16'h0606, 1, 1);
        cs_high();
        check("pushpop_level", fifo_level, 4);
        check("pushpop_ovf", overflow, 0);
        m_ready = 1'b1;
        tick(8);
        check("drained_level", fifo_level, 0);

        cs_low();
        for (int i = 0; i < 4; i++)
            send_bit(2'b10, 0);
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        row = 0;
        check("midrst_valid", m_valid, 0);
        check("midrst_level", fifo_level, 0);
        check("midrst_ferr", frame_err, 0);
        for (int b = 0; b < 8; b++)
            send_bit(2'b01, 0);
        tick(4);
        check("ignored_word", fifo_level, 0);
        cs_high();
        cs_low();
        send_word(16'h2468, 1, 0);
        cs_high();

        for (int i = 0; i < 100 && exp_q.size() != 0; i++)
            tick(1);
        check("drain", exp_q.size(), 0);
        check("ferr_total", err_cycles, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
